// File: rtl/snn_pkg.sv
// Shared SNN definitions: default array sizing (also used by the LFSR) and the
// spike index finder state type.
package snn_pkg;

  localparam int unsigned SNN_N_NEURONS = 100;
  localparam int unsigned SNN_IDX_W     = 7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } scan_state_e;

endpackage

// File: rtl/spike_index_finder.sv
// Picks one spiking neuron per time step: first set bit at or above a random start
// index, wrapping around. Pulses the LFSR enable once per completed selection.
module spike_index_finder
  import snn_pkg::*;
#(
  parameter int unsigned N_NEURONS = SNN_N_NEURONS,
  parameter int unsigned IDX_W     = SNN_IDX_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [N_NEURONS-1:0] spikes_in,
  input  logic [IDX_W-1:0]     rand_idx,
  output logic                 lfsr_enable,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic [IDX_W-1:0]     winner_idx,
  output logic [N_NEURONS-1:0] winner_onehot
);

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [N_NEURONS-1:0] ONE_LSB  = N_NEURONS'(1);

  scan_state_e            r_state, w_state_next;
  logic [N_NEURONS-1:0]   r_spikes, w_spikes_next;
  logic [IDX_W-1:0]       r_ptr, w_ptr_next;
  logic [IDX_W-1:0]       r_scan_cnt, w_scan_cnt_next;
  logic                   r_busy, w_busy_next;
  logic                   r_done, w_done_next;
  logic                   r_lfsr_en, w_lfsr_en_next;
  logic                   r_found, w_found_next;
  logic [IDX_W-1:0]       r_winner_idx, w_winner_idx_next;
  logic [N_NEURONS-1:0]   r_winner_onehot, w_winner_onehot_next;

  logic [IDX_W-1:0]       w_clamped;
  logic [IDX_W-1:0]       w_ptr_wrap;
  logic [N_NEURONS-1:0]   w_ptr_onehot;
  logic                   w_hit;
  logic                   w_spikes_empty;

  // The LFSR range is slightly wider than the array; out-of-range starts pin to the top neuron.
  assign w_clamped      = (rand_idx > LAST_IDX) ? LAST_IDX : rand_idx;
  assign w_ptr_wrap     = (r_ptr == LAST_IDX) ? '0 : r_ptr + 1'b1;
  assign w_ptr_onehot   = ONE_LSB << r_ptr;
  assign w_hit          = r_spikes[r_ptr];
  assign w_spikes_empty = (spikes_in == '0);

  always_comb begin
    w_state_next         = r_state;
    w_spikes_next        = r_spikes;
    w_ptr_next           = r_ptr;
    w_scan_cnt_next      = r_scan_cnt;
    w_busy_next          = r_busy;
    w_done_next          = 1'b0;
    w_lfsr_en_next       = 1'b0;
    w_found_next         = r_found;
    w_winner_idx_next    = r_winner_idx;
    w_winner_onehot_next = r_winner_onehot;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_spikes_next        = spikes_in;
          w_ptr_next           = w_clamped;
          w_scan_cnt_next      = '0;
          w_busy_next          = 1'b1;
          w_found_next         = 1'b0;
          w_winner_idx_next    = '0;
          w_winner_onehot_next = '0;
          if (w_spikes_empty) begin
            w_state_next   = StDone;
            w_done_next    = 1'b1;
            w_lfsr_en_next = 1'b1;
          end else begin
            w_state_next = StScan;
          end
        end
      end

      StScan: begin
        if (w_hit) begin
          w_winner_idx_next    = r_ptr;
          w_winner_onehot_next = w_ptr_onehot;
          w_found_next         = 1'b1;
          w_state_next         = StDone;
          w_done_next          = 1'b1;
          w_lfsr_en_next       = 1'b1;
        end else begin
          w_ptr_next      = w_ptr_wrap;
          w_scan_cnt_next = r_scan_cnt + 1'b1;
          // Safety net: a full lap without a hit cannot happen after the empty-vector check.
          if (r_scan_cnt == LAST_IDX) begin
            w_found_next   = 1'b0;
            w_state_next   = StDone;
            w_done_next    = 1'b1;
            w_lfsr_en_next = 1'b1;
          end
        end
      end

      StDone: begin
        w_state_next = StIdle;
        w_busy_next  = 1'b0;
      end

      default: begin
        w_state_next = StIdle;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= StIdle;
      r_spikes        <= '0;
      r_ptr           <= '0;
      r_scan_cnt      <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_lfsr_en       <= 1'b0;
      r_found         <= 1'b0;
      r_winner_idx    <= '0;
      r_winner_onehot <= '0;
    end else begin
      r_state         <= w_state_next;
      r_spikes        <= w_spikes_next;
      r_ptr           <= w_ptr_next;
      r_scan_cnt      <= w_scan_cnt_next;
      r_busy          <= w_busy_next;
      r_done          <= w_done_next;
      r_lfsr_en       <= w_lfsr_en_next;
      r_found         <= w_found_next;
      r_winner_idx    <= w_winner_idx_next;
      r_winner_onehot <= w_winner_onehot_next;
    end
  end

  assign lfsr_enable   = r_lfsr_en;
  assign busy          = r_busy;
  assign done          = r_done;
  assign found         = r_found;
  assign winner_idx    = r_winner_idx;
  assign winner_onehot = r_winner_onehot;

endmodule

// File: tb/tb_spike_index_finder.sv
// Scoreboard bench for spike_index_finder: expected selections are queued at start
// and compared, including latency, when done pulses.
module tb_spike_index_finder;
  import snn_pkg::*;

  localparam int N = 100;
  localparam int W = 7;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic         start   = 1'b0;
  logic [N-1:0] spikes_in = '0;
  logic [W-1:0] rand_idx  = '0;
  logic         lfsr_enable;
  logic         busy;
  logic         done;
  logic         found;
  logic [W-1:0] winner_idx;
  logic [N-1:0] winner_onehot;

  spike_index_finder #(
    .N_NEURONS (N),
    .IDX_W     (W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .spikes_in     (spikes_in),
    .rand_idx      (rand_idx),
    .lfsr_enable   (lfsr_enable),
    .busy          (busy),
    .done          (done),
    .found         (found),
    .winner_idx    (winner_idx),
    .winner_onehot (winner_onehot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         found;
    logic [W-1:0] idx;
    logic [N-1:0] oh;
    int           lat;
    int           t_acc;
  } exp_t;

  exp_t q[$];
  int   n_checks   = 0;
  int   n_pass     = 0;
  int   cyc        = 0;
  int   n_done     = 0;
  int   n_launched = 0;
  logic prev_done  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: walk offsets from the clamped start until the first spike.
  function automatic exp_t model(input logic [N-1:0] s, input int r);
    exp_t e;
    int   st;
    int   b;
    logic hit;
    st      = (r >= N) ? N - 1 : r;
    e.found = 1'b0;
    e.idx   = '0;
    e.oh    = '0;
    e.lat   = 1;
    e.t_acc = 0;
    hit     = 1'b0;
    for (int k = 0; k < N; k++) begin
      b = (st + k) % N;
      if (!hit && s[b]) begin
        hit     = 1'b1;
        e.found = 1'b1;
        e.idx   = W'(b);
        e.oh[b] = 1'b1;
        e.lat   = k + 2;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (!done) check("lfsr_without_done", 128'(lfsr_enable), 128'(0));
      if (done) begin
        n_done++;
        check("done_one_cycle", 128'(prev_done), 128'(0));
        check("lfsr_with_done", 128'(lfsr_enable), 128'(1));
        check("busy_at_done", 128'(busy), 128'(1));
        if (q.size() == 0) begin
          check("unexpected_done", 128'(1), 128'(0));
        end else begin
          e = q.pop_front();
          check("found", 128'(found), 128'(e.found));
          check("winner_idx", 128'(winner_idx), 128'(e.idx));
          check("winner_onehot", 128'(winner_onehot), 128'(e.oh));
          check("latency", 128'(cyc - e.t_acc + 1), 128'(e.lat));
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Caller must be just after a rising edge with the DUT idle.
  task automatic launch(input logic [N-1:0] s, input int r);
    exp_t e;
    e         = model(s, r);
    spikes_in = s;
    rand_idx  = W'(r);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    e.t_acc = cyc;
    q.push_back(e);
    n_launched++;
    spikes_in = ~s;
    rand_idx  = W'($urandom_range(0, 127));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drained", 128'(q.size()), 128'(0));
    q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, 128'(done), 128'(0));
    check({tag, "_lfsr"}, 128'(lfsr_enable), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_found"}, 128'(found), 128'(0));
    check({tag, "_idx"}, 128'(winner_idx), 128'(0));
    check({tag, "_onehot"}, 128'(winner_onehot), 128'(0));
  endtask

  function automatic logic [N-1:0] bit_at(input int b);
    logic [N-1:0] v;
    v    = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [N-1:0] s;
    int           n_done_snap;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    launch(bit_at(42), 10);               wait_done();
    launch(bit_at(3), 97);                wait_done();
    launch(bit_at(3) | bit_at(98), 97);   wait_done();
    launch(bit_at(99), 100);              wait_done();
    launch(bit_at(5), 5);                 wait_done();
    launch('0, 20);                       wait_done();
    check("empty_holds_found", 128'(found), 128'(0));
    launch(bit_at(9), 10);                wait_done();
    check("result_holds", 128'(winner_idx), 128'(9));

    // Second start during the scan must be dropped.
    launch(bit_at(42), 10);
    repeat (3) @(posedge clk);
    #1;
    start     = 1'b1;
    spikes_in = bit_at(7);
    rand_idx  = '0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    // Reset in the middle of a scan.
    launch(bit_at(42), 10);
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midscan_reset");
    q.delete();
    n_launched--;
    n_done_snap = n_done;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_done_after_reset", 128'(n_done), 128'(n_done_snap));
    launch(bit_at(42), 10);               wait_done();

    for (int i = 0; i < 6; i++) begin
      s = N'({$urandom, $urandom, $urandom, $urandom});
      s = s & N'({$urandom, $urandom, $urandom, $urandom});
      s = s & N'({$urandom, $urandom, $urandom, $urandom});
      launch(s, $urandom_range(0, 127));
      wait_done();
    end
    launch(bit_at($urandom_range(0, N - 1)), $urandom_range(0, 127));
    wait_done();

    repeat (3) @(posedge clk);
    #1;
    check("done_count", 128'(n_done), 128'(n_launched));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
